// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline of NUM_STAGES register slices; bubbles carry zeroed control, flush is synchronous.
// Optional stall-cycle counter output (stall_cnt) is compiled in when PIPE_STAGE_STALL_CNT_EN is defined.
module pipe_stage_elastic #(
  parameter int CTRL_W     = 4,
  parameter int DATA_W     = 72,
  parameter int NUM_STAGES = 1
) (
  input  logic                            clk,
  input  logic                            rstN,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [CTRL_W-1:0]               in_ctrl,
  input  logic [DATA_W-1:0]               in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CTRL_W-1:0]               out_ctrl,
  output logic [DATA_W-1:0]               out_data,
  output logic [$clog2(NUM_STAGES+1)-1:0] occupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [31:0]                     stall_cnt
`endif
);

  localparam int OCC_W = $clog2(NUM_STAGES+1);

  if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_num_stages
    $error("pipe_stage_elastic: NUM_STAGES must be in 1..8");
  end

  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] valid_d;
  logic [CTRL_W-1:0]     ctrl_q [NUM_STAGES];
  logic [DATA_W-1:0]     data_q [NUM_STAGES];
  logic [NUM_STAGES:0]   rdy;
  logic [OCC_W-1:0]      occ_d;

  // Ready ripples backwards: a slice can load if it is empty or its successor is moving.
  always_comb begin
    logic chain;
    chain           = out_ready;
    rdy             = '0;
    rdy[NUM_STAGES] = out_ready;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      chain  = ~valid_q[k] | chain;
      rdy[k] = chain;
    end
  end

  assign in_ready = rdy[0] & ~flush;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slice
    logic              src_valid;
    logic [CTRL_W-1:0] src_ctrl;
    logic [DATA_W-1:0] src_data;
    logic              v_q;
    logic              v_d;
    logic [CTRL_W-1:0] c_q;
    logic [DATA_W-1:0] d_q;

    if (k == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_ctrl  = in_ctrl;
      assign src_data  = in_data;
    end else begin : g_body
      assign src_valid = valid_q[k-1];
      assign src_ctrl  = ctrl_q[k-1];
      assign src_data  = data_q[k-1];
    end

    assign v_d        = flush ? 1'b0 : (rdy[k] ? src_valid : v_q);
    assign valid_q[k] = v_q;
    assign valid_d[k] = v_d;
    assign ctrl_q[k]  = c_q;
    assign data_q[k]  = d_q;

    // Data is left untouched on bubbles and flush; only control must be clean.
    always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
        v_q <= 1'b0;
        c_q <= '0;
        d_q <= '0;
      end else if (flush) begin
        v_q <= 1'b0;
        c_q <= '0;
      end else if (rdy[k]) begin
        v_q <= src_valid;
        c_q <= src_valid ? src_ctrl : '0;
        if (src_valid) d_q <= src_data;
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int k = 0; k < NUM_STAGES; k++) occ_d = occ_d + OCC_W'(valid_d[k]);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) occupancy <= '0;
    else       occupancy <= occ_d;
  end

  assign out_valid = valid_q[NUM_STAGES-1];
  assign out_ctrl  = valid_q[NUM_STAGES-1] ? ctrl_q[NUM_STAGES-1] : '0;
  assign out_data  = data_q[NUM_STAGES-1];

`ifdef PIPE_STAGE_STALL_CNT_EN
  // Counts cycles where a valid beat is held back; sticky at all-ones, survives flush.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
